// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter.
// The LLU entry payload width is fixed here and matches the arbiter's default P_WIDTH.
package wb_port_arbiter_pkg;

    localparam int WB_DATA_W = 32;

    typedef logic [4:0] rf_addr_t;

    typedef enum logic {
        S_NORMAL = 1'b0,
        S_STARVE = 1'b1
    } wb_arb_state_e;

    typedef struct packed {
        rf_addr_t               rd;
        logic [WB_DATA_W-1:0]   data;
        logic                   kill;
    } llu_entry_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundle of the pipeline, LLU and register-file write-port signals around the arbiter.
// The slave modport is the arbiter's view; the master modport is the view of its surroundings.
interface wb_port_arbiter_if #(
    parameter int P_WIDTH = 32,
    parameter int P_DEPTH = 2
);
    import wb_port_arbiter_pkg::*;

    localparam int CW = $clog2(P_DEPTH) + 1;

    logic                i_wb_valid;
    rf_addr_t            i_wb_rd;
    logic [P_WIDTH-1:0]  i_wb_data;
    logic                i_llu_valid;
    rf_addr_t            i_llu_rd;
    logic [P_WIDTH-1:0]  i_llu_data;
    logic                o_llu_ready;
    logic                o_stall_pipe;
    logic                o_rf_we;
    rf_addr_t            o_rf_rd;
    logic [P_WIDTH-1:0]  o_rf_wd;
    logic [CW-1:0]       o_fifo_count;

    modport slave (
        input  i_wb_valid, i_wb_rd, i_wb_data, i_llu_valid, i_llu_rd, i_llu_data,
        output o_llu_ready, o_stall_pipe, o_rf_we, o_rf_rd, o_rf_wd, o_fifo_count
    );

    modport master (
        output i_wb_valid, i_wb_rd, i_wb_data, i_llu_valid, i_llu_rd, i_llu_data,
        input  o_llu_ready, o_stall_pipe, o_rf_we, o_rf_rd, o_rf_wd, o_fifo_count
    );

endinterface

// File: rtl/wb_port_arbiter_llu_fifo.sv
// Purpose: small queue of LLU results with per-entry kill bits for WAW suppression.
// Latency: an entry enqueued at edge N is visible at the head from cycle N+1.
// Backpressure: o_ready from the registered count only; no enqueue while full.
module wb_llu_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int P_WIDTH = 32,
    parameter int P_DEPTH = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_enq,
    input  rf_addr_t                      i_enq_rd,
    input  logic [P_WIDTH-1:0]            i_enq_data,
    input  logic                          i_deq,
    input  logic                          i_kill,
    input  rf_addr_t                      i_kill_rd,
    output llu_entry_t                    o_head,
    output logic [$clog2(P_DEPTH):0]      o_count,
    output logic                          o_ready
);
    localparam int AW = $clog2(P_DEPTH);
    localparam int CW = AW + 1;

    llu_entry_t         mem [P_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic [P_DEPTH-1:0] occ;
    llu_entry_t         enq_entry;

    // A slot is live when its distance from the read pointer is below the count.
    always_comb begin
        occ = '0;
        for (int i = 0; i < P_DEPTH; i++) begin
            occ[i] = ({1'b0, AW'(i) - rd_ptr} < count);
        end
    end

    always_comb begin
        enq_entry      = '0;
        enq_entry.rd   = i_enq_rd;
        enq_entry.data = WB_DATA_W'(i_enq_data);
        enq_entry.kill = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < P_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < P_DEPTH; i++) begin
                if (i_kill && occ[i] && (mem[i].rd == i_kill_rd)) begin
                    mem[i].kill <= 1'b1;
                end
            end
            // Written after the kill scan: a same-cycle enqueue is younger and must survive.
            if (i_enq) begin
                mem[wr_ptr] <= enq_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (i_deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(i_enq) - CW'(i_deq);
        end
    end

    assign o_head  = mem[rd_ptr];
    assign o_count = count;
    assign o_ready = (count < CW'(P_DEPTH));

endmodule

// File: rtl/wb_port_arbiter.sv
// Purpose: share the register-file write port between pipeline writeback and queued LLU results.
// Latency: a write granted in cycle N drives o_rf_* in cycle N+1; LLU-to-port minimum is 2 cycles.
// Backpressure: LLU sees o_llu_ready (FIFO not full); pipeline sees o_stall_pipe after starvation.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int P_WIDTH  = 32,
    parameter int P_DEPTH  = 2,
    parameter int P_STARVE = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    wb_port_arbiter_if.slave  bus
);
    localparam int CW = $clog2(P_DEPTH) + 1;
    localparam int SW = $clog2(P_STARVE + 1);

    llu_entry_t         head;
    logic [CW-1:0]      count;
    logic               fifo_ready;
    logic               fifo_nonempty;
    logic               wb_grant;
    logic               deq;
    logic               enq;
    logic               enq_accept;

    logic               rf_we_q;
    rf_addr_t           rf_rd_q;
    logic [P_WIDTH-1:0] rf_wd_q;
    logic [SW-1:0]      starve_cnt;
    wb_arb_state_e      state_q;
    wb_arb_state_e      state_d;
    logic               stall_pipe;

    // A pipeline request to x0 is treated as an idle port cycle.
    assign wb_grant      = bus.i_wb_valid && (bus.i_wb_rd != '0);
    assign fifo_nonempty = (count != '0);
    assign deq           = !wb_grant && fifo_nonempty;
    assign enq_accept    = bus.i_llu_valid && fifo_ready;
    assign enq           = enq_accept && (bus.i_llu_rd != '0);

    wb_llu_fifo #(
        .P_WIDTH (P_WIDTH),
        .P_DEPTH (P_DEPTH)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_enq      (enq),
        .i_enq_rd   (bus.i_llu_rd),
        .i_enq_data (bus.i_llu_data),
        .i_deq      (deq),
        .i_kill     (wb_grant),
        .i_kill_rd  (bus.i_wb_rd),
        .o_head     (head),
        .o_count    (count),
        .o_ready    (fifo_ready)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rf_we_q <= 1'b0;
            rf_rd_q <= '0;
            rf_wd_q <= '0;
        end else if (wb_grant) begin
            rf_we_q <= 1'b1;
            rf_rd_q <= bus.i_wb_rd;
            rf_wd_q <= bus.i_wb_data;
        end else if (deq) begin
            // A killed head still burns the grant cycle, just without a write.
            rf_we_q <= !head.kill;
            if (!head.kill) begin
                rf_rd_q <= head.rd;
                rf_wd_q <= P_WIDTH'(head.data);
            end
        end else begin
            rf_we_q <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            starve_cnt <= '0;
        end else if (deq || !fifo_nonempty) begin
            starve_cnt <= '0;
        end else if (wb_grant && (starve_cnt != SW'(P_STARVE))) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= S_NORMAL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        stall_pipe = 1'b0;
        case (state_q)
            S_NORMAL: begin
                if (wb_grant && fifo_nonempty && (starve_cnt == SW'(P_STARVE - 1))) begin
                    state_d = S_STARVE;
                end
            end
            S_STARVE: begin
                stall_pipe = 1'b1;
                if (deq || !fifo_nonempty) begin
                    state_d = S_NORMAL;
                end
            end
            default: state_d = S_NORMAL;
        endcase
    end

    assign bus.o_llu_ready  = fifo_ready;
    assign bus.o_stall_pipe = stall_pipe;
    assign bus.o_rf_we      = rf_we_q;
    assign bus.o_rf_rd      = rf_rd_q;
    assign bus.o_rf_wd      = rf_wd_q;
    assign bus.o_fifo_count = count;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_wb_port_arbiter;

    localparam int W      = 32;
    localparam int DEPTH  = 2;
    localparam int STARVE = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    wb_port_arbiter_if #(.P_WIDTH(W), .P_DEPTH(DEPTH)) bus ();

    wb_port_arbiter #(
        .P_WIDTH  (W),
        .P_DEPTH  (DEPTH),
        .P_STARVE (STARVE)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic [4:0]   rd;
        logic [W-1:0] data;
        logic         kill;
    } ment_t;

    ment_t        mq[$];
    logic         m_we;
    logic [4:0]   m_rd;
    logic [W-1:0] m_wd;
    int           m_grants_waiting;
    logic         m_stall;

    int errors = 0;
    int checks = 0;

    task automatic drive(input logic wv, input logic [4:0] wrd, input logic [W-1:0] wd,
                         input logic lv, input logic [4:0] lrd, input logic [W-1:0] ld);
        bus.i_wb_valid  = wv;
        bus.i_wb_rd     = wrd;
        bus.i_wb_data   = wd;
        bus.i_llu_valid = lv;
        bus.i_llu_rd    = lrd;
        bus.i_llu_data  = ld;
    endtask

    // Reference behaviour for one clock edge, stated in terms of the queue of pending LLU results.
    task automatic model_edge();
        int n;
        logic room;
        ment_t e;
        if (!rst_n) begin
            mq.delete();
            m_we = 1'b0; m_rd = '0; m_wd = '0;
            m_grants_waiting = 0; m_stall = 1'b0;
        end else begin
            n    = mq.size();
            room = (n < DEPTH);
            if (bus.i_wb_valid && bus.i_wb_rd != 5'd0) begin
                m_we = 1'b1; m_rd = bus.i_wb_rd; m_wd = bus.i_wb_data;
                foreach (mq[i]) if (mq[i].rd == bus.i_wb_rd) mq[i].kill = 1'b1;
                if (n > 0) begin
                    m_grants_waiting++;
                    if (m_grants_waiting >= STARVE) m_stall = 1'b1;
                end else begin
                    m_grants_waiting = 0; m_stall = 1'b0;
                end
            end else if (n > 0) begin
                e = mq.pop_front();
                m_we = !e.kill;
                if (!e.kill) begin m_rd = e.rd; m_wd = e.data; end
                m_grants_waiting = 0; m_stall = 1'b0;
            end else begin
                m_we = 1'b0;
                m_grants_waiting = 0; m_stall = 1'b0;
            end
            if (bus.i_llu_valid && room && bus.i_llu_rd != 5'd0)
                mq.push_back('{rd: bus.i_llu_rd, data: bus.i_llu_data, kill: 1'b0});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.o_rf_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", bus.o_rf_we); end
        checks++; if (bus.o_rf_rd !== 5'd0) begin errors++; $display("FAIL reset_rd got=%0d exp=0", bus.o_rf_rd); end
        checks++; if (bus.o_rf_wd !== 32'd0) begin errors++; $display("FAIL reset_wd got=%h exp=0", bus.o_rf_wd); end
        checks++; if (bus.o_stall_pipe !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", bus.o_stall_pipe); end
        checks++; if (bus.o_fifo_count !== 2'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.o_fifo_count); end
        checks++; if (bus.o_llu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.o_llu_ready); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1, 4, 32'h1, 1, 12, 32'hC1); tick();
        drive(1, 4, 32'h2, 1, 13, 32'hC2); tick();
        checks++; if (bus.o_fifo_count !== 2'd2) begin errors++; $display("FAIL midrst_fill got=%0d exp=2", bus.o_fifo_count); end
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0); tick();
        rst_n = 1'b1;
        checks++; if (bus.o_fifo_count !== 2'd0) begin errors++; $display("FAIL midrst_count got=%0d exp=0", bus.o_fifo_count); end
        checks++; if (bus.o_rf_we !== 1'b0) begin errors++; $display("FAIL midrst_we got=%b exp=0", bus.o_rf_we); end
        checks++; if (bus.o_llu_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b exp=1", bus.o_llu_ready); end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (bus.o_rf_we !== 1'b0) begin errors++; $display("FAIL midrst_after cyc=%0d we=%b exp=0", k, bus.o_rf_we); end
        end
    endtask

    task automatic test_llu_only();
        do_reset();
        drive(0, 0, 0, 1, 5, 32'hDEADBEEF); tick();
        drive(0, 0, 0, 0, 0, 0);
        checks++; if (bus.o_rf_we !== 1'b0) begin errors++; $display("FAIL llu_early_we got=%b exp=0", bus.o_rf_we); end
        checks++; if (bus.o_fifo_count !== 2'd1) begin errors++; $display("FAIL llu_count got=%0d exp=1", bus.o_fifo_count); end
        tick();
        checks++; if (bus.o_rf_we !== 1'b1 || bus.o_rf_rd !== 5'd5 || bus.o_rf_wd !== 32'hDEADBEEF) begin
            errors++; $display("FAIL llu_write we=%b rd=%0d wd=%h exp=1/5/deadbeef", bus.o_rf_we, bus.o_rf_rd, bus.o_rf_wd);
        end
    endtask

    task automatic test_starve();
        do_reset();
        drive(1, 3, 32'h100, 1, 7, 32'h77); tick();
        checks++; if (bus.o_rf_rd !== 5'd3 || bus.o_fifo_count !== 2'd1) begin
            errors++; $display("FAIL starve_setup rd=%0d count=%0d exp=3/1", bus.o_rf_rd, bus.o_fifo_count);
        end
        for (int k = 1; k <= 4; k++) begin
            drive(1, 3, 32'h100 + k, 0, 0, 0); tick();
            checks++; if (bus.o_stall_pipe !== (k == 4)) begin
                errors++; $display("FAIL starve_stall grant=%0d got=%b exp=%b", k, bus.o_stall_pipe, (k == 4));
            end
        end
        drive(0, 0, 0, 0, 0, 0); tick();
        checks++; if (bus.o_rf_we !== 1'b1 || bus.o_rf_rd !== 5'd7 || bus.o_rf_wd !== 32'h77) begin
            errors++; $display("FAIL starve_bubble we=%b rd=%0d wd=%h exp=1/7/77", bus.o_rf_we, bus.o_rf_rd, bus.o_rf_wd);
        end
        checks++; if (bus.o_stall_pipe !== 1'b0) begin errors++; $display("FAIL starve_release got=%b exp=0", bus.o_stall_pipe); end
    endtask

    task automatic test_waw();
        do_reset();
        drive(0, 0, 0, 1, 9, 32'h11); tick();
        drive(1, 9, 32'h22, 0, 0, 0); tick();
        checks++; if (bus.o_rf_we !== 1'b1 || bus.o_rf_rd !== 5'd9 || bus.o_rf_wd !== 32'h22) begin
            errors++; $display("FAIL waw_pipe we=%b rd=%0d wd=%h exp=1/9/22", bus.o_rf_we, bus.o_rf_rd, bus.o_rf_wd);
        end
        drive(0, 0, 0, 0, 0, 0); tick();
        checks++; if (bus.o_rf_we !== 1'b0 || bus.o_fifo_count !== 2'd0) begin
            errors++; $display("FAIL waw_killed we=%b count=%0d exp=0/0", bus.o_rf_we, bus.o_fifo_count);
        end
        drive(1, 9, 32'h33, 1, 9, 32'h44); tick();
        drive(0, 0, 0, 0, 0, 0); tick();
        checks++; if (bus.o_rf_we !== 1'b1 || bus.o_rf_wd !== 32'h44) begin
            errors++; $display("FAIL waw_younger we=%b wd=%h exp=1/44", bus.o_rf_we, bus.o_rf_wd);
        end
    endtask

    task automatic test_full();
        do_reset();
        drive(1, 4, 32'h1, 1, 10, 32'hA0); tick();
        drive(1, 4, 32'h2, 1, 11, 32'hB0); tick();
        checks++; if (bus.o_fifo_count !== 2'd2 || bus.o_llu_ready !== 1'b0) begin
            errors++; $display("FAIL full_state count=%0d ready=%b exp=2/0", bus.o_fifo_count, bus.o_llu_ready);
        end
        drive(1, 4, 32'h3, 1, 12, 32'hC0); tick();
        checks++; if (bus.o_fifo_count !== 2'd2) begin errors++; $display("FAIL full_hold count=%0d exp=2", bus.o_fifo_count); end
        drive(0, 0, 0, 1, 12, 32'hC0); tick();
        checks++; if (bus.o_fifo_count !== 2'd1 || bus.o_rf_rd !== 5'd10) begin
            errors++; $display("FAIL full_deq_noenq count=%0d rd=%0d exp=1/10", bus.o_fifo_count, bus.o_rf_rd);
        end
        drive(0, 0, 0, 1, 12, 32'hC0); tick();
        checks++; if (bus.o_fifo_count !== 2'd1 || bus.o_rf_rd !== 5'd11) begin
            errors++; $display("FAIL full_accept count=%0d rd=%0d exp=1/11", bus.o_fifo_count, bus.o_rf_rd);
        end
        drive(0, 0, 0, 0, 0, 0); tick();
        checks++; if (bus.o_rf_we !== 1'b1 || bus.o_rf_rd !== 5'd12 || bus.o_rf_wd !== 32'hC0) begin
            errors++; $display("FAIL full_third we=%b rd=%0d wd=%h exp=1/12/c0", bus.o_rf_we, bus.o_rf_rd, bus.o_rf_wd);
        end
    endtask

    task automatic test_rd_zero();
        do_reset();
        drive(1, 0, 32'hAA, 1, 0, 32'hBB); tick();
        drive(0, 0, 0, 0, 0, 0);
        checks++; if (bus.o_fifo_count !== 2'd0) begin errors++; $display("FAIL rd0_count got=%0d exp=0", bus.o_fifo_count); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (bus.o_rf_we !== 1'b0) begin errors++; $display("FAIL rd0_we cyc=%0d got=%b exp=0", k, bus.o_rf_we); end
            tick();
        end
    endtask

    task automatic test_random();
        logic wv;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            wv = m_stall ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 2) != 0);
            drive(wv, 5'($urandom_range(0, 7)), $urandom(),
                  ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom());
            tick();
            checks++; if (bus.o_rf_we !== m_we) begin errors++; $display("FAIL rand_we cyc=%0d got=%b exp=%b", c, bus.o_rf_we, m_we); end
            if (m_we) begin
                checks++; if (bus.o_rf_rd !== m_rd || bus.o_rf_wd !== m_wd) begin
                    errors++; $display("FAIL rand_wr cyc=%0d got=%0d/%h exp=%0d/%h", c, bus.o_rf_rd, bus.o_rf_wd, m_rd, m_wd);
                end
            end
            checks++; if (bus.o_fifo_count !== 2'(mq.size())) begin
                errors++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", c, bus.o_fifo_count, mq.size());
            end
            checks++; if (bus.o_llu_ready !== (mq.size() < DEPTH)) begin
                errors++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, bus.o_llu_ready, (mq.size() < DEPTH));
            end
            checks++; if (bus.o_stall_pipe !== m_stall) begin
                errors++; $display("FAIL rand_stall cyc=%0d got=%b exp=%b", c, bus.o_stall_pipe, m_stall);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        test_reset();
        test_llu_only();
        test_starve();
        test_waw();
        test_full();
        test_rd_zero();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
